// File: rtl/red_pitaya_iq_capture_block.sv
// Triggered, decimating I/Q capture into a bus-readable FIFO.
// Boxcar-averages both quadratures over 2^dec_shift samples per word.
module red_pitaya_iq_capture_block #(
    parameter int SIGNALBITS = 14,
    parameter int DEPTHBITS  = 10,
    parameter int MAXDECBITS = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  trig_i,
    input  logic [SIGNALBITS-1:0] dat1_i,
    input  logic [SIGNALBITS-1:0] dat2_i,
    input  logic [15:0]           addr,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  done_o
);

    localparam int ACCW  = SIGNALBITS + MAXDECBITS;
    localparam int DEPTH = 2**DEPTHBITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                   trig_q, trig_p, trig_edge;
    logic [4:0]             dec_shift;
    logic [DEPTHBITS:0]     n_samples, words, target, level;
    logic [DEPTHBITS-1:0]   wr_ptr, rd_ptr;
    logic [31:0]            mem [DEPTH];
    logic signed [ACCW-1:0] acc_i, acc_q, avg_i, avg_q;
    logic signed [ACCW-1:0] s_i, s_q;
    logic [MAXDECBITS:0]    nacc, blk_len;
    logic                   overflow, underflow;
    logic                   ctrl_wr, cfg_ok, abort, arm, sw_trig, fifo_clr;
    logic                   cap_run, blk_full, push, pop, pop_req, full, push_ok;
    logic [31:0]            word, rd_mux;
    logic                   unused_bits;

    assign ctrl_wr  = wen && (addr == 16'h0100);
    assign cfg_ok   = (state == IDLE) || (state == DONE);
    assign abort    = ctrl_wr && wdata[2];
    assign arm      = ctrl_wr && wdata[0] && !wdata[2] && cfg_ok;
    assign sw_trig  = ctrl_wr && wdata[1] && !wdata[2] && (state == ARMED);
    assign fifo_clr = abort || arm;

    assign target   = (n_samples == '0) ? (DEPTHBITS+1)'(DEPTH) : n_samples;
    assign cap_run  = (state == CAPTURE) && !abort && (words != target);
    assign blk_len  = (MAXDECBITS+1)'(1) << dec_shift;
    assign blk_full = (nacc == blk_len);
    assign push     = cap_run && blk_full;

    assign pop_req  = ren && (addr == 16'h0110);
    assign pop      = pop_req && (level != '0);
    assign full     = (level == (DEPTHBITS+1)'(DEPTH));
    assign push_ok  = push && (!full || pop);

    assign s_i   = {{MAXDECBITS{dat1_i[SIGNALBITS-1]}}, dat1_i};
    assign s_q   = {{MAXDECBITS{dat2_i[SIGNALBITS-1]}}, dat2_i};
    assign avg_i = acc_i >>> dec_shift;
    assign avg_q = acc_q >>> dec_shift;
    assign word  = {avg_i[15:0], avg_q[15:0]};

    assign done_o = (state == DONE);

    assign unused_bits = ^{wdata[31:DEPTHBITS+1],
                           avg_i[ACCW-1:16], avg_q[ACCW-1:16]};

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; abort wins over everything
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (arm) state_nxt = ARMED;
                ARMED:   if (sw_trig || trig_edge) state_nxt = CAPTURE;
                CAPTURE: if (words == target) state_nxt = DONE;
                DONE:    if (arm) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Trigger synchroniser and rising-edge flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            trig_q    <= 1'b0;
            trig_p    <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            trig_q    <= trig_i;
            trig_p    <= trig_q;
            trig_edge <= trig_q && !trig_p;
        end
    end

    // Configuration registers, writable only while not capturing
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dec_shift <= '0;
            n_samples <= '0;
        end else if (wen && cfg_ok) begin
            if (addr == 16'h0104) begin
                dec_shift <= (wdata[4:0] > 5'(MAXDECBITS)) ?
                             5'(MAXDECBITS) : wdata[4:0];
            end
            if (addr == 16'h0108) n_samples <= wdata[DEPTHBITS:0];
        end
    end

    // Boxcar accumulators; a full block is emitted while reloading
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_i <= '0;
            acc_q <= '0;
            nacc  <= '0;
            words <= '0;
        end else if (cap_run) begin
            if (blk_full) begin
                acc_i <= s_i;
                acc_q <= s_q;
                nacc  <= (MAXDECBITS+1)'(1);
                words <= words + 1'b1;
            end else begin
                acc_i <= acc_i + s_i;
                acc_q <= acc_q + s_q;
                nacc  <= nacc + 1'b1;
            end
        end else if (state != CAPTURE) begin
            acc_i <= '0;
            acc_q <= '0;
            nacc  <= '0;
            words <= '0;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (!push_ok && pop) level <= level - 1'b1;
        end
    end

    // FIFO storage, no reset so it maps onto RAM
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= word;
    end

    // Sticky overflow/underflow flags, cleared by arm
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (arm) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok)         overflow  <= 1'b1;
            if (pop_req && level == '0)   underflow <= 1'b1;
        end
    end

    // Read-data multiplexer
    always_comb begin
        rd_mux = '0;
        case (addr)
            16'h0100: rd_mux = {27'b0, underflow, overflow, 1'b0, state};
            16'h0104: rd_mux = {27'b0, dec_shift};
            16'h0108: rd_mux = 32'(n_samples);
            16'h010C: rd_mux = 32'(level);
            16'h0110: rd_mux = (level != '0) ? mem[rd_ptr] : 32'd0;
            16'h0200: rd_mux = 32'(SIGNALBITS);
            16'h0204: rd_mux = 32'(DEPTHBITS);
            16'h0208: rd_mux = 32'(MAXDECBITS);
            default:  rd_mux = '0;
        endcase
    end

    // Registered bus response
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= wen || ren;
            rdata <= ren ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_iq_capture_block.sv
// Bench for red_pitaya_iq_capture_block: queue-based model checked
// every cycle, plus directed reads with hand-computed literals.
module tb_red_pitaya_iq_capture_block;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trig = 1'b0;
    logic [13:0] d1 = '0;
    logic [13:0] d2 = '0;
    logic [15:0] addr = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic [31:0] rdata;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    red_pitaya_iq_capture_block #(
        .SIGNALBITS(14),
        .DEPTHBITS (3),
        .MAXDECBITS(16)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .trig_i(trig),
        .dat1_i(d1),
        .dat2_i(d2),
        .addr  (addr),
        .wen   (wen),
        .ren   (ren),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .done_o(done)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;
    logic [31:0] m_q[$];
    bit          m_ovf, m_unf;
    int          m_dec, m_nsamp;
    bit          m_t1, m_t2, m_edge;
    longint      m_si, m_sq;
    int          m_nacc, m_words;
    bit          m_ack, m_rd;
    logic [31:0] m_rdata;

    bit          x_cfg, x_ctrl, x_abort, x_arm, x_swt, x_push, x_pop, x_unf;
    int          x_tgt, x_nst;
    logic [31:0] x_word;

    function automatic logic [15:0] favg(input longint s, input int sh);
        longint p;
        longint f;
        p = longint'(1) << sh;
        if (s >= 0) f = s / p;
        else        f = -((-s + p - 1) / p);
        return f[15:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
            m_dec = 0; m_nsamp = 0; m_t1 = 0; m_t2 = 0; m_edge = 0;
            m_si = 0; m_sq = 0; m_nacc = 0; m_words = 0;
            m_ack = 0; m_rd = 0; m_rdata = 0;
        end else begin
            x_cfg   = (m_state == 0) || (m_state == 3);
            x_ctrl  = wen && addr == 16'h0100;
            x_abort = x_ctrl && wdata[2];
            x_arm   = x_ctrl && wdata[0] && !wdata[2] && x_cfg;
            x_swt   = x_ctrl && wdata[1] && !wdata[2] && m_state == 1;
            x_tgt   = (m_nsamp == 0) ? DEPTH : m_nsamp;
            x_nst   = m_state;
            if (x_abort) x_nst = 0;
            else if (x_cfg && x_arm) x_nst = 1;
            else if (m_state == 1 && (x_swt || m_edge)) x_nst = 2;
            else if (m_state == 2 && m_words == x_tgt) x_nst = 3;
            m_rdata = 0; x_pop = 0; x_unf = 0;
            if (ren) begin
                case (addr)
                    16'h0100: m_rdata = (m_unf ? 16 : 0) + (m_ovf ? 8 : 0) + m_state;
                    16'h0104: m_rdata = m_dec;
                    16'h0108: m_rdata = m_nsamp;
                    16'h010C: m_rdata = m_q.size();
                    16'h0110: begin
                        if (m_q.size() > 0) begin
                            m_rdata = m_q[0];
                            x_pop = 1;
                        end else x_unf = 1;
                    end
                    16'h0200: m_rdata = 14;
                    16'h0204: m_rdata = 3;
                    16'h0208: m_rdata = 16;
                    default:  m_rdata = 0;
                endcase
            end
            m_ack = wen || ren;
            m_rd  = ren;
            x_push = 0;
            if (m_state == 2 && !x_abort && m_words != x_tgt) begin
                if (m_nacc == (1 << m_dec)) begin
                    x_word = {favg(m_si, m_dec), favg(m_sq, m_dec)};
                    x_push = 1;
                    m_words++;
                    m_si = longint'($signed(d1));
                    m_sq = longint'($signed(d2));
                    m_nacc = 1;
                end else begin
                    m_si += longint'($signed(d1));
                    m_sq += longint'($signed(d2));
                    m_nacc++;
                end
            end else if (m_state != 2) begin
                m_si = 0; m_sq = 0; m_nacc = 0; m_words = 0;
            end
            if (x_abort || x_arm) begin
                m_q.delete();
            end else begin
                if (x_pop) void'(m_q.pop_front());
                if (x_push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(x_word);
                    else m_ovf = 1;
                end
            end
            if (x_arm) begin
                m_ovf = 0;
                m_unf = 0;
            end else if (x_unf) m_unf = 1;
            if (wen && x_cfg && addr == 16'h0104)
                m_dec = (wdata[4:0] > 16) ? 16 : int'(wdata[4:0]);
            if (wen && x_cfg && addr == 16'h0108)
                m_nsamp = int'(wdata[3:0]);
            m_edge  = m_t1 && !m_t2;
            m_t2    = m_t1;
            m_t1    = trig;
            m_state = x_nst;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rstn) begin
            chk("ack", 32'(ack), 32'(m_ack));
            if (m_ack && m_rd) chk("rdata", rdata, m_rdata);
            chk("done_o", 32'(done), (m_state == 3) ? 32'd1 : 32'd0);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        wen = 1'b1; addr = a; wdata = d;
        @(negedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk); #1;
        ren = 1'b1; addr = a;
        @(negedge clk);
        d = rdata;
        #1 ren = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [15:0] a,
                         input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #12 rstn = 1'b1;

        rdchk("rst_status", 16'h0100, 32'h0);
        rdchk("rst_dec", 16'h0104, 32'h0);
        rdchk("rst_nsamp", 16'h0108, 32'h0);
        rdchk("rst_level", 16'h010C, 32'h0);
        rdchk("par_sig", 16'h0200, 32'd14);
        rdchk("par_depth", 16'h0204, 32'd3);
        rdchk("par_maxdec", 16'h0208, 32'd16);
        rdchk("other_addr", 16'h0300, 32'h0);

        // Ramp on I, Q=-5, external trigger, one sample per word
        wr(16'h0108, 32'd4);
        wr(16'h0104, 32'd0);
        d2 = 14'h3FFB;
        wr(16'h0100, 32'h1);
        @(negedge clk); #1 trig = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); #1 d1 = 14'd1;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk); #1 d1 = 14'(k);
        end
        trig = 1'b0;
        rdchk("t1_status", 16'h0100, 32'h3);
        rdchk("t1_level", 16'h010C, 32'd4);
        rdchk("t1_w0", 16'h0110, 32'h0001FFFB);
        rdchk("t1_w1", 16'h0110, 32'h0002FFFB);
        rdchk("t1_w2", 16'h0110, 32'h0003FFFB);
        rdchk("t1_w3", 16'h0110, 32'h0004FFFB);

        // Average of four: I=100, Q alternating 3/-4 -> floor(-0.5)=-1
        wr(16'h0104, 32'd2);
        wr(16'h0108, 32'd2);
        wr(16'h0100, 32'h1);
        d1 = 14'd100;
        d2 = 14'd3;
        wr(16'h0100, 32'h2);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); #1;
            d2 = (d2 == 14'd3) ? 14'h3FFC : 14'd3;
        end
        rdchk("t2_level", 16'h010C, 32'd2);
        rdchk("t2_w0", 16'h0110, 32'h0064FFFF);
        rdchk("t2_w1", 16'h0110, 32'h0064FFFF);
        rdchk("t2_status", 16'h0100, 32'h3);

        // n_samples=0 fills the whole FIFO without overflow
        wr(16'h0104, 32'd0);
        wr(16'h0108, 32'd0);
        wr(16'h0100, 32'h1);
        wr(16'h0100, 32'h2);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); #1;
            d1 = 14'($urandom); d2 = 14'($urandom);
        end
        rdchk("t3_status", 16'h0100, 32'h3);
        rdchk("t3_level", 16'h010C, 32'd8);

        // Nine words into eight slots: last one dropped
        wr(16'h0108, 32'd9);
        wr(16'h0100, 32'h1);
        wr(16'h0100, 32'h2);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            d1 = 14'($urandom); d2 = 14'($urandom);
        end
        rdchk("t4_status", 16'h0100, 32'hB);
        rdchk("t4_level", 16'h010C, 32'd8);

        // Back-to-back drain, then an underflowing read
        @(negedge clk); #1;
        ren = 1'b1; addr = 16'h0110;
        repeat (8) @(negedge clk);
        #1 ren = 1'b0;
        rdchk("drain_level", 16'h010C, 32'd0);
        rdchk("empty_pop", 16'h0110, 32'h0);
        rdchk("unf_status", 16'h0100, 32'h1B);
        wr(16'h0100, 32'h1);
        rdchk("arm_clears", 16'h0100, 32'h1);

        // Config is locked while armed
        wr(16'h0104, 32'd5);
        wr(16'h0108, 32'd7);
        rdchk("lock_dec", 16'h0104, 32'd0);
        rdchk("lock_nsamp", 16'h0108, 32'd9);

        // Abort mid-capture with words in the FIFO
        wr(16'h0100, 32'h2);
        idle(4);
        wr(16'h0100, 32'h4);
        rdchk("abort_status", 16'h0100, 32'h0);
        rdchk("abort_level", 16'h010C, 32'd0);

        // Trigger edge ignored in IDLE
        trig = 1'b1;
        idle(3);
        trig = 1'b0;
        idle(3);
        rdchk("idle_trig", 16'h0100, 32'h0);

        // dec_shift clamps to the maximum
        wr(16'h0104, 32'd31);
        rdchk("dec_clamp", 16'h0104, 32'd16);

        // Asynchronous reset in the middle of a capture
        wr(16'h0104, 32'd4);
        wr(16'h0108, 32'd0);
        wr(16'h0100, 32'h1);
        wr(16'h0100, 32'h2);
        idle(20);
        @(negedge clk); #1;
        ren = 1'b1; addr = 16'h010C;
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(ack), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_ack_async", 32'(ack), 32'd0);
        chk("rst_done_async", 32'(done), 32'd0);
        chk("rst_rdata_async", rdata, 32'd0);
        ren = 1'b0;
        @(negedge clk); #1 rstn = 1'b1;
        rdchk("post_rst_status", 16'h0100, 32'h0);
        rdchk("post_rst_level", 16'h010C, 32'd0);
        rdchk("post_rst_dec", 16'h0104, 32'd0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/red_pitaya_iq_capture_block.md
# red_pitaya_iq_capture_block

Triggered, decimating capture buffer that sits directly downstream of the IQ demodulator block. It consumes the two 14-bit quadrature outputs and boxcar-averages both over 2^N samples. Each I/Q pair is packed into a 32-bit word and pushed into an on-chip FIFO, which the PS drains over the standard addr/wen/ren/ack bus. It provides time-resolved quadrature traces without going through the scope.

## Interface
- SIGNALBITS, 14, input sample width (signed)
- DEPTHBITS, 10, log2 FIFO depth in 32-bit words
- MAXDECBITS, 16, maximum decimation exponent; accumulators are SIGNALBITS+MAXDECBITS wide
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- trig_i  in  1  external trigger, rising-edge sensitive
- dat1_i  in  14  signed I quadrature
- dat2_i  in  14  signed Q quadrature
- addr  in  16  bus address
- wen  in  1  bus write strobe
- ren  in  1  bus read strobe
- wdata  in  32  bus write data
- ack  out  1  bus acknowledge, registered
- rdata  out  32  bus read data, registered
- done_o  out  1  high while state==DONE

## Operation
- States: IDLE(0), ARMED(1), CAPTURE(2), DONE(3). Reset: IDLE, FIFO empty, all flags 0, dec_shift=0, n_samples=0, ack=0, rdata=0, done_o=0.
- 0x100 write:
  - bit0=arm: IDLE/DONE → ARMED; clears FIFO, overflow and underflow.
  - bit1=sw_trig: ARMED → CAPTURE.
  - bit2=abort: any state → IDLE; clears FIFO.
  - Bits are strobes and are not stored.
  - Priority: abort > arm > sw_trig.
  - arm is ignored in ARMED/CAPTURE. sw_trig is ignored outside ARMED.
- 0x100 read: {27'b0, underflow[4], overflow[3], 1'b0, state[1:0]}.
- 0x104 dec_shift[4:0]:
  - Values > MAXDECBITS are stored as MAXDECBITS.
  - Written only in IDLE/DONE, ignored otherwise.
  - Reads back the stored value.
- 0x108 n_samples[DEPTHBITS:0]: number of words to capture. 0 means 2^DEPTHBITS. Same write restriction as 0x104.
- 0x10C read: FIFO fill level (0..2^DEPTHBITS).
- 0x110 read: returns the head word and pops it. If the FIFO is empty, returns 0 and sets sticky underflow. Writes are ignored.
- Registers 0x200/0x204/0x208 read back SIGNALBITS/DEPTHBITS/MAXDECBITS. Any other address reads 0.
- Trigger: trig_i is registered once. An edge is prev=0, cur=1. An edge in ARMED moves to CAPTURE; edges in other states are ignored.
- CAPTURE datapath:
  - Both channels sign-extend and accumulate every cycle.
  - After 2^dec_shift samples, word = {sext16(accI>>>dec_shift), sext16(accQ>>>dec_shift)}, with I in [31:16].
  - The accumulator reloads with the current sample, so there are no dropped input cycles.
  - Shift is arithmetic with truncation toward −∞.
- After n_samples words have been produced (pushed or dropped), go to DONE. Partial accumulations are discarded on abort.
- FIFO full at a push: the word is dropped and overflow is set sticky. If a pop occurs in the same cycle, the push succeeds.
- Push and pop in the same cycle: level unchanged, order preserved. Read-out is allowed in every state.

## Timing
- Bus: ack is asserted exactly one cycle after any wen|ren, for all addresses. rdata is valid in the ack cycle.
- Pop on read: the FIFO head advances in the ack cycle. Back-to-back reads on consecutive cycles return consecutive words.
- Trigger latency:
  - trig_i rises before edge t. The edge detector flags at t+1.
  - State is CAPTURE after t+2. The first accumulated sample is dat*_i at edge t+3.
  - sw_trig: CAPTURE one cycle after the write edge.
- Each word is pushed one cycle after its last sample. The fill level reflects it in the same cycle as the push.
- done_o rises one cycle after the last word's push/drop.
- Asynchronous reset mid-capture immediately forces all reset values. The FIFO contents are lost.

## Test plan
- Reset mid-CAPTURE → state=0, level=0, ack=0, done_o=0 without waiting for a clock edge.
- dec_shift=0, n_samples=4, arm, trig_i edge, I ramp 1,2,3,… and Q=−5 → four words starting 0x0001FFFB, consecutive I, DONE, level=4.
- dec_shift=2, n_samples=2, I constant 100, Q alternating 3/−4 → both words 0x0064FFFF.
- DEPTHBITS=3, n_samples=0, dec_shift=0, no reads → 8 pushes, then DONE after 8 words with overflow=0. Repeat with n_samples=9 written as 9 (>depth): 9th word dropped, overflow=1, level=8.
- Read 0x110 on empty FIFO → rdata=0, ack one cycle later, underflow=1. Then arm → underflow=0.
- In ARMED, write 0x104 and 0x108 → ignored. Abort → IDLE, level=0. Trigger edge in IDLE → stays IDLE.
